reduce_nway_acc: RTL and testbench
==================================

# reduce_nway_acc

Parametrised, registered N-way reduction unit and successor to the fixed 8-input OR gate. It reduces each WIDTH-bit input word to a single bit (OR, AND, XOR or NOR) and accumulates that result across a burst of words delivered under a valid/ready handshake. It also keeps a bitwise accumulated vector and presents both in a held output register until the consumer accepts them. It sits between a word stream (e.g. a memory scan or ALU flag collector) and control logic that needs one "any/all/parity" verdict per burst.

## Interface
Parameters:
- WIDTH, 8, bits per input word (≥1)
- MAX_WORDS, 16, maximum beats per burst (≥1)
- CNT_W, $clog2(MAX_WORDS+1), width of beat counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; one clock; returns all state to reset values immediately
- in_valid  input  1  input beat present
- in_ready  output  1  unit can accept a beat
- in_data  input  WIDTH  input word
- in_last  input  1  final beat of burst
- mode  input  2  00 OR, 01 AND, 10 XOR, 11 NOR; sampled on first beat only
- out_valid  output  1  result held
- out_ready  input  1  consumer accepts result
- out_bit  output  1  burst reduction result
- out_vec  output  WIDTH  bitwise combine of all words in burst (same operator; NOR mode uses OR)
- out_count  output  CNT_W  beats accepted in burst
- overflow  output  1  burst was truncated at MAX_WORDS

## Operation
- Beat accepted when in_valid && in_ready. Word reduction r = |in_data, &in_data or ^in_data per latched mode (NOR uses |).
- States:
  - IDLE: in_ready=1, out_valid=0. On accept: latch mode; acc=r; vec=in_data; count=1; overflow=0. Go to HOLD if in_last or MAX_WORDS==1 (the latter without in_last sets overflow); else go to ACC.
  - ACC: in_ready=1. On accept: acc=acc op r; vec=vec op in_data; count+1. On in_last, go to HOLD. If count reaches MAX_WORDS without in_last: set overflow=1 and go to HOLD; later beats belong to the next burst.
  - HOLD: in_ready=0, out_valid=1. Outputs are stable. On out_ready, go to IDLE.
- out_bit = acc, inverted in NOR mode.
- Changes to mode after the first beat are ignored until the next burst.
- in_data and in_last are don't-care when in_valid=0. ACC waits indefinitely for beats.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_bit=0, out_vec=0, out_count=0, overflow=0.
- Latency: out_valid rises on the clock edge that accepts the last beat. Result is visible the cycle after that beat.
- Minimum burst period: single-beat burst = 1 accept cycle + ≥1 HOLD cycle. No bypass from HOLD to a new beat in the same cycle.
- out_ready while out_valid=0: ignored.
- Reset mid-burst or mid-HOLD: the partial result is discarded and all reset values apply immediately. The first beat after release starts a new burst.
- Counter never wraps: maximum value MAX_WORDS.

## Configuration
- REDUCE_FIRST_IDX_EN defined: adds ports out_first_hit (output, 1) and out_first_idx (output, CNT_W).
  - out_first_idx is the 0-based beat index of the first beat with r=1.
  - out_first_hit is 1 if any beat had r=1.
  - Both are valid with out_valid and reset to 0. They work in all modes.
- REDUCE_FIRST_IDX_EN undefined: these ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset, then a single beat 8'b00000000, OR, last: out_bit=0, out_vec=00, out_count=1, overflow=0, out_valid one cycle after accept.
- OR burst 00000000, 00010000, 00000000, last: out_bit=1, out_vec=8'h10, out_count=3. With REDUCE_FIRST_IDX_EN: first_hit=1, first_idx=1.
- AND burst FF, FF, 7F: out_bit=0, out_vec=7F. Same with all FF: out_bit=1. XOR burst 00100110, 00000001 (parity 1,1): out_bit=0, out_vec=27.
- NOR single beat 00000000: out_bit=1. Hold out_ready=0 for 5 cycles: outputs stable and in_ready=0. On out_ready=1, back to IDLE next cycle.
- MAX_WORDS=4, 6 OR beats without last: after beat 4, out_valid=1, overflow=1, out_count=4. Beats 5–6 stall until accepted, then start a new burst.
- Assert reset during ACC after 2 beats: all outputs return to 0 immediately. A following single-beat burst reports out_count=1.

Source files
------------

// File: rtl/reduce_nway_acc.sv
// Registered N-way OR/AND/XOR/NOR reduction over a valid/ready burst, result held in HOLD until out_ready.
// Result visible the cycle after the last beat; in_ready low while holding. Optional first-hit index: REDUCE_FIRST_IDX_EN.
module reduce_nway_acc #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [WIDTH-1:0] out_vec,
    output logic [CNT_W-1:0] out_count,
`ifdef REDUCE_FIRST_IDX_EN
    output logic             overflow,
    output logic             out_first_hit,
    output logic [CNT_W-1:0] out_first_idx
`else
    output logic             overflow
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t             state;
    logic [1:0]         mode_q;
    logic               acc;
    logic [WIDTH-1:0]   vec;
    logic [CNT_W-1:0]   count;

    logic               first;
    logic [1:0]         eff_mode;
    logic               r;
    logic               acc_nxt;
    logic [WIDTH-1:0]   vec_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               full;

    always_comb begin
        first    = (state == S_IDLE);
        // The first beat of a burst uses the live mode; later beats use the latched one.
        eff_mode = first ? mode : mode_q;
        case (eff_mode)
            2'b01:   r = &in_data;
            2'b10:   r = ^in_data;
            default: r = |in_data;
        endcase
        case (mode_q)
            2'b01: begin
                acc_nxt = acc & r;
                vec_nxt = vec & in_data;
            end
            2'b10: begin
                acc_nxt = acc ^ r;
                vec_nxt = vec ^ in_data;
            end
            default: begin
                acc_nxt = acc | r;
                vec_nxt = vec | in_data;
            end
        endcase
        if (first) begin
            acc_nxt = r;
            vec_nxt = in_data;
        end
        cnt_nxt = first ? CNT_W'(1) : count + CNT_W'(1);
        full    = (cnt_nxt == MAX_CNT);
    end

    assign in_ready  = (state != S_HOLD);
    assign out_valid = (state == S_HOLD);
    assign out_bit   = (mode_q == 2'b11) ? ~acc : acc;
    assign out_vec   = vec;
    assign out_count = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mode_q   <= 2'b00;
            acc      <= 1'b0;
            vec      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACC: begin
                    if (in_valid) begin
                        if (first) mode_q <= mode;
                        acc      <= acc_nxt;
                        vec      <= vec_nxt;
                        count    <= cnt_nxt;
                        // A full burst closed by in_last is complete, not truncated.
                        overflow <= full && !in_last;
                        state    <= (in_last || full) ? S_HOLD : S_ACC;
                    end
                end
                S_HOLD: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef REDUCE_FIRST_IDX_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_first_hit <= 1'b0;
            out_first_idx <= '0;
        end else if (in_valid && in_ready) begin
            if (first) begin
                out_first_hit <= r;
                out_first_idx <= '0;
            end else if (r && !out_first_hit) begin
                out_first_hit <= 1'b1;
                out_first_idx <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reduce_nway_acc.sv
// Randomized + directed bench for reduce_nway_acc against a burst-level reference model.
module tb_reduce_nway_acc;

    localparam int W   = 8;
    localparam int MAX = 4;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_bit;
    logic [W-1:0]  out_vec;
    logic [CW-1:0] out_count;
    logic          overflow;
`ifdef REDUCE_FIRST_IDX_EN
    logic          out_first_hit;
    logic [CW-1:0] out_first_idx;
`endif

    reduce_nway_acc #(.WIDTH(W), .MAX_WORDS(MAX)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_vec(out_vec), .out_count(out_count),
`ifdef REDUCE_FIRST_IDX_EN
        .overflow(overflow), .out_first_hit(out_first_hit), .out_first_idx(out_first_idx)
`else
        .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: words of the current burst and the mode of its first beat.
    logic [W-1:0] mq[$];
    logic [1:0]   mmode;
    logic         e_bit;
    logic [W-1:0] e_vec;
    int           e_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit word_hit(input logic [W-1:0] w, input logic [1:0] m);
        if (m == 2'b01) return (w == {W{1'b1}});
        if (m == 2'b10) return ($countones(w) % 2) == 1;
        return (w != '0);
    endfunction

    task automatic check_result(input bit last_seen);
        int hit_idx;
        hit_idx = -1;
        e_vec = mq[0];
        for (int i = 0; i < mq.size(); i++) begin
            if (hit_idx < 0 && word_hit(mq[i], mmode)) hit_idx = i;
            if (i > 0) begin
                case (mmode)
                    2'b01:   e_vec = e_vec & mq[i];
                    2'b10:   e_vec = e_vec ^ mq[i];
                    default: e_vec = e_vec | mq[i];
                endcase
            end
        end
        case (mmode)
            2'b00: e_bit = (hit_idx >= 0);
            2'b01: begin
                e_bit = 1'b1;
                foreach (mq[i]) if (mq[i] != {W{1'b1}}) e_bit = 1'b0;
            end
            2'b10: begin
                int ones;
                ones = 0;
                foreach (mq[i]) ones += $countones(mq[i]);
                e_bit = (ones % 2) == 1;
            end
            default: e_bit = (hit_idx < 0);
        endcase
        e_cnt = mq.size();
        check("res_valid", out_valid, 1);
        check("res_in_ready", in_ready, 0);
        check("res_bit", out_bit, e_bit);
        check("res_vec", out_vec, e_vec);
        check("res_count", out_count, e_cnt);
        check("res_overflow", overflow, (!last_seen && e_cnt == MAX));
`ifdef REDUCE_FIRST_IDX_EN
        check("res_first_hit", out_first_hit, hit_idx >= 0);
        if (hit_idx >= 0) check("res_first_idx", out_first_idx, hit_idx);
`endif
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic beat(input logic [W-1:0] d, input bit l, input logic [1:0] m, output bit closed);
        int n;
        closed = 0;
        in_valid = 1'b1; in_data = d; in_last = l; mode = m;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        if (mq.size() == 0) begin
            mmode = m;
            check("idle_out_valid", out_valid, 0);
        end
        @(posedge clk);
        mq.push_back(d);
        @(negedge clk);
        in_valid = 1'b0; in_data = W'($urandom); in_last = 1'($urandom); mode = 2'($urandom);
        if (l || mq.size() == MAX) begin
            check_result(l);
            mq.delete();
            closed = 1;
        end else begin
            check("acc_no_valid", out_valid, 0);
        end
    endtask

    task automatic drain(input int hold);
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_bit", out_bit, e_bit);
            check("hold_vec", out_vec, e_vec);
            check("hold_count", out_count, e_cnt);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("drain_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_bit"}, out_bit, 0);
        check({tag, "_out_vec"}, out_vec, 0);
        check({tag, "_out_count"}, out_count, 0);
        check({tag, "_overflow"}, overflow, 0);
`ifdef REDUCE_FIRST_IDX_EN
        check({tag, "_first_hit"}, out_first_hit, 0);
        check({tag, "_first_idx"}, out_first_idx, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit c;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // Single-beat OR of zero.
        beat(8'h00, 1, 2'b00, c); drain(1);
        // OR burst with one hit in the middle.
        beat(8'h00, 0, 2'b00, c); beat(8'h10, 0, 2'b11, c); beat(8'h00, 1, 2'b01, c); drain(0);
        // AND bursts.
        beat(8'hFF, 0, 2'b01, c); beat(8'hFF, 0, 2'b01, c); beat(8'h7F, 1, 2'b01, c); drain(1);
        beat(8'hFF, 0, 2'b01, c); beat(8'hFF, 0, 2'b01, c); beat(8'hFF, 1, 2'b01, c); drain(1);
        // XOR parity.
        beat(8'h26, 0, 2'b10, c); beat(8'h01, 1, 2'b10, c); drain(1);
        // NOR single beat held for 5 cycles.
        beat(8'h00, 1, 2'b11, c); drain(5);

        // Truncation at MAX words, next beat stalls during HOLD.
        for (int i = 0; i < MAX; i++) beat(8'h00 | W'(i), 0, 2'b00, c);
        in_valid = 1'b1; in_data = 8'h40; in_last = 1'b0; mode = 2'b00;
        drain(3);
        beat(8'h40, 0, 2'b00, c);
        beat(8'h00, 1, 2'b00, c);
        drain(1);

        // Reset in the middle of a burst.
        beat(8'h01, 0, 2'b00, c); beat(8'h02, 0, 2'b00, c);
        reset = 1'b1;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        beat(8'h00, 1, 2'b00, c);
        drain(0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] d;
            case ($urandom_range(0, 3))
                0: d = '0;
                1: d = '1;
                2: d = W'(1) << $urandom_range(0, W - 1);
                default: d = W'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                out_ready = 1'($urandom);
                @(negedge clk);
                out_ready = 1'b0;
            end
            beat(d, ($urandom_range(0, 3) == 0), 2'($urandom), c);
            if (c) drain($urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
